// File: rtl/cr_fifo_wrap3_if.sv
// Handshake/status bundle for cr_fifo_wrap3.
// slave: FIFO side. master: producer/consumer side.
interface cr_fifo_wrap3_if #(
    parameter int unsigned N_DATA_BITS = 64,
    parameter int unsigned CW          = 4
);
    logic                   clear;
    logic [N_DATA_BITS-1:0] wdata;
    logic                   wen;
    logic                   ren;
    logic [CW-1:0]          afull_thresh;
    logic [CW-1:0]          aempty_thresh;
    logic [N_DATA_BITS-1:0] rdata;
    logic                   full;
    logic                   empty;
    logic                   afull;
    logic                   aempty;
    logic [CW-1:0]          used_slots;
    logic [CW-1:0]          free_slots;
    logic                   overflow;
    logic                   underflow;
    logic [CW-1:0]          hwm;

    modport slave (
        input  clear, wdata, wen, ren, afull_thresh, aempty_thresh,
        output rdata, full, empty, afull, aempty, used_slots, free_slots,
               overflow, underflow, hwm
    );

    modport master (
        output clear, wdata, wen, ren, afull_thresh, aempty_thresh,
        input  rdata, full, empty, afull, aempty, used_slots, free_slots,
               overflow, underflow, hwm
    );
endinterface

// File: rtl/cr_fifo_wrap3.sv
// First-word-fall-through flop FIFO with programmable almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow status.
// Optional high-water-mark monitor enabled by defining CR_FIFO_WRAP3_HWM_EN.
module cr_fifo_wrap3 #(
    parameter int unsigned N_DATA_BITS = 64,
    parameter int unsigned N_ENTRIES   = 8,
    parameter int unsigned DATA_RESET  = 1
) (
    input  logic           clk,
    input  logic           rst,
    cr_fifo_wrap3_if.slave bus
);
    localparam int unsigned CW = $clog2(N_ENTRIES + 1);
    localparam int unsigned PW = $clog2(N_ENTRIES);
    localparam logic [CW-1:0] DEPTH = CW'(N_ENTRIES);
    localparam logic [PW-1:0] LAST  = PW'(N_ENTRIES - 1);

    logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];
    logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   afull_q, afull_d, aempty_q, aempty_d;
    logic                   ovf_q, ovf_d, udf_q, udf_d;
    logic                   full, empty, wr_acc, rd_acc;

    assign full  = (cnt_q == DEPTH);
    assign empty = (cnt_q == '0);

    // Next-state: accept/drop decisions, pointers, count, flags; clear overrides traffic.
    always_comb begin
        wr_acc = bus.wen & ~full;
        rd_acc = bus.ren & ~empty;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | (bus.wen & full);
        udf_d  = udf_q | (bus.ren & empty);
        if (wr_acc) wp_d = (wp_q == LAST) ? '0 : wp_q + PW'(1);
        if (rd_acc) rp_d = (rp_q == LAST) ? '0 : rp_q + PW'(1);
        if (wr_acc && !rd_acc) begin
            cnt_d = cnt_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (bus.clear) begin
            wr_acc = 1'b0;
            rd_acc = 1'b0;
            wp_d   = '0;
            rp_d   = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end
        // Free slots never exceed DEPTH, so a threshold >= DEPTH pins the flag high.
        afull_d  = (DEPTH - cnt_d) <= bus.afull_thresh;
        aempty_d = cnt_d <= bus.aempty_thresh;
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; only cleared when DATA_RESET is set.
    always_ff @(posedge clk) begin
        if ((DATA_RESET != 0) && (rst || bus.clear)) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc && !rst) begin
            mem_q[wp_q] <= bus.wdata;
        end
    end

`ifdef CR_FIFO_WRAP3_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    // Peak occupancy tracker, restarted by clear.
    always_comb begin
        hwm_d = (cnt_d > hwm_q) ? cnt_d : hwm_q;
        if (bus.clear) hwm_d = '0;
    end

    // High-water-mark register.
    always_ff @(posedge clk) begin
        if (rst) hwm_q <= '0;
        else     hwm_q <= hwm_d;
    end

    assign bus.hwm = hwm_q;
`else
    assign bus.hwm = '0;
`endif

    assign bus.rdata      = mem_q[rp_q];
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.afull      = afull_q;
    assign bus.aempty     = aempty_q;
    assign bus.used_slots = cnt_q;
    assign bus.free_slots = DEPTH - cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = udf_q;
endmodule

// File: tb/tb_cr_fifo_wrap3.sv
// Scoreboard bench for cr_fifo_wrap3: an 8-entry and a 5-entry instance share
// stimulus, gated by sel so only the selected one sees traffic.
module tb_cr_fifo_wrap3;
`ifdef CR_FIFO_WRAP3_HWM_EN
    localparam int HWM_FULL = 8;
`else
    localparam int HWM_FULL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       clear = 1'b0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] wdata = '0;
    logic [3:0] afull_t = 4'd2;
    logic [3:0] aempty_t = 4'd2;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    cr_fifo_wrap3_if #(.N_DATA_BITS(8), .CW(4)) if8 ();
    cr_fifo_wrap3_if #(.N_DATA_BITS(8), .CW(3)) if5 ();

    cr_fifo_wrap3 #(.N_DATA_BITS(8), .N_ENTRIES(8), .DATA_RESET(1)) u_dut8 (
        .clk(clk), .rst(rst), .bus(if8.slave)
    );
    cr_fifo_wrap3 #(.N_DATA_BITS(8), .N_ENTRIES(5), .DATA_RESET(1)) u_dut5 (
        .clk(clk), .rst(rst), .bus(if5.slave)
    );

    assign if8.clear         = clear & ~sel;
    assign if8.wen           = wen & ~sel;
    assign if8.ren           = ren & ~sel;
    assign if8.wdata         = wdata;
    assign if8.afull_thresh  = afull_t;
    assign if8.aempty_thresh = aempty_t;
    assign if5.clear         = clear & sel;
    assign if5.wen           = wen & sel;
    assign if5.ren           = ren & sel;
    assign if5.wdata         = wdata;
    assign if5.afull_thresh  = afull_t[2:0];
    assign if5.aempty_thresh = aempty_t[2:0];

    logic [7:0] o_rdata;
    logic [3:0] o_used, o_free, o_hwm;
    logic       o_full, o_empty, o_afull, o_aempty, o_ovf, o_udf;
    assign o_rdata  = sel ? if5.rdata : if8.rdata;
    assign o_used   = sel ? {1'b0, if5.used_slots} : if8.used_slots;
    assign o_free   = sel ? {1'b0, if5.free_slots} : if8.free_slots;
    assign o_hwm    = sel ? {1'b0, if5.hwm} : if8.hwm;
    assign o_full   = sel ? if5.full : if8.full;
    assign o_empty  = sel ? if5.empty : if8.empty;
    assign o_afull  = sel ? if5.afull : if8.afull;
    assign o_aempty = sel ? if5.aempty : if8.aempty;
    assign o_ovf    = sel ? if5.overflow : if8.overflow;
    assign o_udf    = sel ? if5.underflow : if8.underflow;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of traffic; push d as an expected read-out if the write will land.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input bit push);
        wen   = w;
        ren   = r;
        wdata = d;
        if (push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    // Monitor: every accepted pop must present the oldest expected word.
    always @(negedge clk) begin
        if (!rst && ren && !o_empty && !clear) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got %0h expected no read (queue empty)", o_rdata);
            end else begin
                if (o_rdata !== exp_q[0]) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", o_rdata, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_full", int'(o_full), 0);
        chk("rst_aempty", int'(o_aempty), 1);
        chk("rst_afull", int'(o_afull), 0);
        chk("rst_used", int'(o_used), 0);
        chk("rst_free", int'(o_free), 8);
        chk("rst_ovf", int'(o_ovf), 0);
        chk("rst_udf", int'(o_udf), 0);
        chk("rst_hwm", int'(o_hwm), 0);
        chk("rst_rdata", int'(o_rdata), 0);
        rst = 1'b0;

        // Fill 0x1..0x8 with thresholds 2/2.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 8'(k), 1'b1);
            chk($sformatf("fill_used_%0d", k), int'(o_used), k);
            chk($sformatf("fill_afull_%0d", k), int'(o_afull), (k >= 6) ? 1 : 0);
            chk($sformatf("fill_full_%0d", k), int'(o_full), (k == 8) ? 1 : 0);
        end
        chk("fill_free", int'(o_free), 0);
        chk("fill_hwm", int'(o_hwm), HWM_FULL);

        // Drain 8.
        for (int j = 1; j <= 8; j++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk($sformatf("drain_aempty_%0d", j), int'(o_aempty), (j >= 6) ? 1 : 0);
        end
        chk("drain_empty", int'(o_empty), 1);

        // Overflow: full + wen + ren, write dropped.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'h11 + 8'(k), 1'b1);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("ovf_flag", int'(o_ovf), 1);
        chk("ovf_used", int'(o_used), 7);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("ovf_drained", int'(o_empty), 1);

        // Underflow with simultaneous write.
        step(1'b1, 1'b1, 8'h05, 1'b1);
        chk("udf_flag", int'(o_udf), 1);
        chk("udf_used", int'(o_used), 1);
        chk("udf_rdata", int'(o_rdata), 5);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Threshold change at occupancy 4.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h21 + 8'(k), 1'b1);
        chk("thr_afull_pre", int'(o_afull), 0);
        afull_t = 4'd4;
        #1;
        chk("thr_afull_same_cycle", int'(o_afull), 0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("thr_afull_next_edge", int'(o_afull), 1);
        aempty_t = 4'd9;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("thr_aempty_9", int'(o_aempty), 1);
        step(1'b1, 1'b0, 8'h25, 1'b1);
        chk("thr_aempty_9_occ5", int'(o_aempty), 1);
        afull_t  = 4'd2;
        aempty_t = 4'd2;

        // Clear mid-stream: reach 8, overflow, drop to 6.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h26 + 8'(k), 1'b1);
        step(1'b1, 1'b0, 8'h99, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("clr_pre_used", int'(o_used), 6);
        chk("clr_pre_ovf", int'(o_ovf), 1);
        chk("clr_pre_hwm", int'(o_hwm), HWM_FULL);
        clear = 1'b1;
        step(1'b1, 1'b1, 8'h77, 1'b0);
        clear = 1'b0;
        exp_q.delete();
        chk("clr_empty", int'(o_empty), 1);
        chk("clr_used", int'(o_used), 0);
        chk("clr_ovf", int'(o_ovf), 0);
        chk("clr_udf", int'(o_udf), 0);
        chk("clr_hwm", int'(o_hwm), 0);
        chk("clr_afull", int'(o_afull), 0);
        chk("clr_aempty", int'(o_aempty), 1);
        chk("clr_rdata", int'(o_rdata), 0);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        chk("clr_wr_rdata", int'(o_rdata), 8'h33);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Wrap-around on the 5-entry instance at occupancy 3.
        sel = 1'b1;
        #1;
        chk("w5_empty", int'(o_empty), 1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h40 + 8'(k), 1'b1);
        for (int i = 0; i < 23; i++) begin
            step(1'b1, 1'b1, 8'h43 + 8'(i), 1'b1);
            chk($sformatf("w5_used_%0d", i), int'(o_used), 3);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("w5_drained", int'(o_empty), 1);
        chk("sb_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case stimulus stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end
endmodule
